// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl
//   Game-flow controller for the Pong datapath. Sequences a match through
//   IDLE -> SERVE -> PLAY -> SCORED -> (SERVE | GAMEOVER), detects goals from
//   the ball X position once per video frame, keeps both scores and declares
//   the winner.
//
// Ports
//   clk          system clock (only clock)
//   rst          asynchronous active-high reset
//   frame_tick   one-cycle pulse per video frame
//   start        start/restart key level (already synchronous to clk)
//   ballX        current ball X position
//   ball_run     high while the ball may move
//   ball_reload  one-cycle pulse: recentre the ball
//   serve_dir    0 = serve toward player 1 (left), 1 = toward player 2 (right)
//   score1/2     player scores
//   game_over    match finished
//   winner       0 = player 1, 1 = player 2 (valid while game_over)
//   state        current FSM state code
module pong_match_ctrl #(
   parameter int SCORE_W      = 4,
   parameter int WIN_SCORE    = 7,
   parameter int SERVE_FRAMES = 60,
   parameter int LEFT_GOAL    = 8,
   parameter int RIGHT_GOAL   = 624
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_tick,
   input  logic               start,
   input  logic [9:0]         ballX,
   output logic               ball_run,
   output logic               ball_reload,
   output logic               serve_dir,
   output logic [SCORE_W-1:0] score1,
   output logic [SCORE_W-1:0] score2,
   output logic               game_over,
   output logic               winner,
   output logic [2:0]         state
);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SERVE    = 3'd1,
      PLAY     = 3'd2,
      SCORED   = 3'd3,
      GAMEOVER = 3'd4
   } state_t;

   // Counter holds 0 .. SERVE_FRAMES-1; the last tick is recognised by value.
   localparam int CNT_W = (SERVE_FRAMES > 1) ? $clog2(SERVE_FRAMES) : 1;
   localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SERVE_FRAMES - 1);
   localparam logic [SCORE_W-1:0] WIN_VAL  = SCORE_W'(WIN_SCORE);
   localparam logic [9:0]         LEFT_X   = 10'(LEFT_GOAL);
   localparam logic [9:0]         RIGHT_X  = 10'(RIGHT_GOAL);

   state_t             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [SCORE_W-1:0] score1_q, score2_q;
   logic               scorer_q;   // 0 = player 1 scored, 1 = player 2 scored
   logic               run_q, reload_q, dir_q, over_q, winner_q, start_q;

   logic               start_edge;
   logic [SCORE_W-1:0] score1_d, score2_d;

   assign start_edge = start & ~start_q;

   // Saturating increments; only the scorer's value is committed in SCORED.
   assign score1_d = (score1_q >= WIN_VAL) ? WIN_VAL : score1_q + 1'b1;
   assign score2_d = (score2_q >= WIN_VAL) ? WIN_VAL : score2_q + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         score1_q <= '0;
         score2_q <= '0;
         scorer_q <= 1'b0;
         run_q    <= 1'b0;
         reload_q <= 1'b0;
         dir_q    <= 1'b0;
         over_q   <= 1'b0;
         winner_q <= 1'b0;
         start_q  <= 1'b0;
      end else begin
         start_q  <= start;
         reload_q <= 1'b0;   // pulse unless a SERVE entry below re-asserts it
         case (state_q)
            IDLE: begin
               run_q <= 1'b0;
               if (start_edge) begin
                  score1_q <= '0;
                  score2_q <= '0;
                  dir_q    <= 1'b0;
                  reload_q <= 1'b1;
                  cnt_q    <= '0;
                  state_q  <= SERVE;
               end
            end
            SERVE: begin
               run_q <= 1'b0;
               if (frame_tick) begin
                  if (cnt_q == CNT_LAST) begin
                     run_q   <= 1'b1;
                     state_q <= PLAY;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end
            PLAY: begin
               run_q <= 1'b1;
               if (frame_tick) begin
                  // Left miss has priority over right miss.
                  if (ballX <= LEFT_X) begin
                     scorer_q <= 1'b1;
                     run_q    <= 1'b0;
                     state_q  <= SCORED;
                  end else if (ballX >= RIGHT_X) begin
                     scorer_q <= 1'b0;
                     run_q    <= 1'b0;
                     state_q  <= SCORED;
                  end
               end
            end
            SCORED: begin
               run_q <= 1'b0;
               if (!scorer_q) score1_q <= score1_d;
               else           score2_q <= score2_d;
               if ((!scorer_q && score1_d == WIN_VAL) || (scorer_q && score2_d == WIN_VAL)) begin
                  over_q   <= 1'b1;
                  winner_q <= scorer_q;
                  state_q  <= GAMEOVER;
               end else begin
                  // Serve toward the player who conceded.
                  dir_q    <= ~scorer_q;
                  reload_q <= 1'b1;
                  cnt_q    <= '0;
                  state_q  <= SERVE;
               end
            end
            GAMEOVER: begin
               run_q  <= 1'b0;
               over_q <= 1'b1;
               if (start_edge) begin
                  score1_q <= '0;
                  score2_q <= '0;
                  over_q   <= 1'b0;
                  winner_q <= 1'b0;
                  dir_q    <= 1'b0;
                  reload_q <= 1'b1;
                  cnt_q    <= '0;
                  state_q  <= SERVE;
               end
            end
            default: begin
               // Unused codes recover to IDLE.
               run_q   <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign ball_run    = run_q;
   assign ball_reload = reload_q;
   assign serve_dir   = dir_q;
   assign score1      = score1_q;
   assign score2      = score2_q;
   assign game_over   = over_q;
   assign winner      = winner_q;
   assign state       = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
module tb_pong_match_ctrl;

   localparam int SW  = 4;
   localparam int WIN = 3;
   localparam int SF  = 4;
   localparam int LG  = 8;
   localparam int RG  = 624;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          frame_tick = 1'b0;
   logic          start = 1'b0;
   logic [9:0]    ballX = 10'd320;
   logic          ball_run, ball_reload, serve_dir, game_over, winner;
   logic [SW-1:0] score1, score2;
   logic [2:0]    state;

   pong_match_ctrl #(
      .SCORE_W(SW), .WIN_SCORE(WIN), .SERVE_FRAMES(SF),
      .LEFT_GOAL(LG), .RIGHT_GOAL(RG)
   ) dut (
      .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .ballX(ballX),
      .ball_run(ball_run), .ball_reload(ball_reload), .serve_dir(serve_dir),
      .score1(score1), .score2(score2), .game_over(game_over), .winner(winner),
      .state(state)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int reload_seen = 0;

   // Behavioural model: phase names 0..4, scorer as player number 1/2,
   // serve delay as frames remaining.
   int m_phase, m_s1, m_s2, m_scorer, m_wait;
   bit m_run, m_reload, m_dir, m_go, m_win, m_prev_start;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      m_phase = 0; m_s1 = 0; m_s2 = 0; m_scorer = 0; m_wait = 0;
      m_run = 0; m_reload = 0; m_dir = 0; m_go = 0; m_win = 0; m_prev_start = 0;
   endtask

   task automatic m_enter_serve();
      m_reload = 1;
      m_phase  = 1;
      m_wait   = SF;
   endtask

   task automatic m_step(input bit s, input bit ft, input int bx);
      bit edge_s;
      edge_s = s && !m_prev_start;
      m_prev_start = s;
      m_reload = 0;
      case (m_phase)
         0: if (edge_s) begin
               m_s1 = 0; m_s2 = 0; m_dir = 0;
               m_enter_serve();
            end
         1: if (ft) begin
               m_wait = m_wait - 1;
               if (m_wait == 0) begin m_phase = 2; m_run = 1; end
            end
         2: if (ft) begin
               if (bx <= LG)      begin m_scorer = 2; m_phase = 3; m_run = 0; end
               else if (bx >= RG) begin m_scorer = 1; m_phase = 3; m_run = 0; end
            end
         3: begin
               int ns;
               if (m_scorer == 1) begin ns = (m_s1 + 1 > WIN) ? WIN : m_s1 + 1; m_s1 = ns; end
               else               begin ns = (m_s2 + 1 > WIN) ? WIN : m_s2 + 1; m_s2 = ns; end
               if (ns == WIN) begin
                  m_go = 1; m_win = (m_scorer == 2); m_phase = 4;
               end else begin
                  m_dir = (m_scorer == 1);
                  m_enter_serve();
               end
            end
         default: if (edge_s) begin
               m_s1 = 0; m_s2 = 0; m_go = 0; m_win = 0; m_dir = 0;
               m_enter_serve();
            end
      endcase
   endtask

   task automatic compare_all(input string where);
      check({where, ".state"},  32'(state),       32'(m_phase));
      check({where, ".score1"}, 32'(score1),      32'(m_s1));
      check({where, ".score2"}, 32'(score2),      32'(m_s2));
      check({where, ".run"},    32'(ball_run),    32'(m_run));
      check({where, ".reload"}, 32'(ball_reload), 32'(m_reload));
      check({where, ".dir"},    32'(serve_dir),   32'(m_dir));
      check({where, ".over"},   32'(game_over),   32'(m_go));
      check({where, ".winner"}, 32'(winner),      32'(m_win));
   endtask

   // One clock: drive inputs, clock, advance model, compare 1 time unit later.
   task automatic cycle(input bit s, input bit ft, input int bx, input string where);
      start = s; frame_tick = ft; ballX = 10'(bx);
      @(posedge clk);
      m_step(s, ft, bx);
      #1;
      if (ball_reload === 1'b1) reload_seen++;
      compare_all(where);
   endtask

   task automatic serve(input string where);
      repeat (SF) cycle(1'b0, 1'b1, 320, where);
   endtask

   task automatic goal(input int bx, input string where);
      cycle(1'b0, 1'b1, bx, where);
      cycle(1'b0, 1'b0, 320, where);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all("reset");
      rst = 1'b0;

      // Held start gives one reload; PLAY exactly on the SF-th tick.
      reload_seen = 0;
      repeat (5) cycle(1'b1, 1'b0, 320, "start_hold");
      check("reload_count", 32'(reload_seen), 32'd1);
      check("serve_state", 32'(state), 32'd1);
      for (int i = 1; i <= SF; i++) begin
         cycle(1'b0, 1'b1, 320, "serve_count");
         check("serve_to_play", 32'(state), (i == SF) ? 32'd2 : 32'd1);
      end

      // Left and right goals at the exact boundary values.
      cycle(1'b0, 1'b1, LG, "left_goal");
      check("scored_state", 32'(state), 32'd3);
      cycle(1'b0, 1'b0, 320, "left_goal");
      check("left_score2", 32'(score2), 32'd1);
      check("left_dir", 32'(serve_dir), 32'd0);
      check("left_reload", 32'(ball_reload), 32'd1);
      serve("serve2");
      goal(RG, "right_goal");
      check("right_score1", 32'(score1), 32'd1);
      check("right_dir", 32'(serve_dir), 32'd1);
      serve("serve3");

      // Goal position without frame_tick never scores.
      repeat (100) cycle(1'b0, 1'b0, 5, "no_tick");
      check("no_tick_score2", 32'(score2), 32'd1);
      goal(5, "tick_goal");
      check("tick_score2", 32'(score2), 32'd2);
      serve("serve4");

      // Player 1 reaches WIN_SCORE.
      goal(RG, "p1_goal2");
      serve("serve5");
      goal(RG, "p1_win");
      check("win_score1", 32'(score1), 32'd3);
      check("win_over", 32'(game_over), 32'd1);
      check("win_winner", 32'(winner), 32'd0);
      check("win_state", 32'(state), 32'd4);
      repeat (5) cycle(1'b0, 1'b1, 700, "gameover_ticks");
      check("gameover_hold", 32'(score1), 32'd3);

      // Restart from GAMEOVER, then a start edge in PLAY does nothing.
      cycle(1'b1, 1'b0, 320, "restart");
      check("restart_state", 32'(state), 32'd1);
      check("restart_over", 32'(game_over), 32'd0);
      serve("serve6");
      cycle(1'b0, 1'b0, 320, "play_start");
      cycle(1'b1, 1'b0, 320, "play_start");
      check("play_start_state", 32'(state), 32'd2);

      // Async reset during PLAY with score1 = 2.
      cycle(1'b0, 1'b0, 320, "pre_rst");
      goal(RG, "pre_rst");
      serve("pre_rst");
      goal(RG, "pre_rst");
      serve("pre_rst");
      check("pre_rst_score1", 32'(score1), 32'd2);
      #2 rst = 1'b1;
      #1;
      m_reset();
      compare_all("async_rst");
      @(posedge clk);
      #1 rst = 1'b0;
      compare_all("after_rst");

      // Randomised match play against the model.
      begin
         bit s_lvl;
         s_lvl = 1'b0;
         for (int i = 0; i < 3000; i++) begin
            int r, bx;
            bit ft;
            if ($urandom_range(0, 15) == 0) s_lvl = ~s_lvl;
            ft = ($urandom_range(0, 2) == 0);
            r  = $urandom_range(0, 9);
            if (r < 3)      bx = $urandom_range(0, LG + 1);
            else if (r < 6) bx = $urandom_range(RG - 1, 1023);
            else            bx = $urandom_range(LG + 1, RG - 1);
            cycle(s_lvl, ft, bx, "rand");
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
